// File: rtl/mips_control_register_write_scheduler.sv
// mips_control_register_write_scheduler
//
// Shares the single register-file write port between the in-order writeback
// stage and one long-latency unit. It also keeps a pending-write scoreboard so
// decode stalls on RAW/WAW hazards against long-latency destinations.
//
// Ports:
//   clock, resetN          clock, asynchronous active-low reset
//   wbValid/wbAddr/wbData  writeback result (absolute priority, never stalled)
//   luValid/luAddr/luData  long-latency result offer
//   luReady                long-latency result accepted this cycle
//   reserveValid/Addr      decode issues a long-latency op to this destination
//   readAddr1/readAddr2    decode source registers
//   decodeWriteValid/Addr  decode destination register
//   hazardStall            hold decode (source or destination pending)
//   starveStall            hold fetch/decode so a writeback bubble appears
//   writeEnable/Addr/Data  registered register-file write port
module mips_control_register_write_scheduler #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clock,
   input  logic        resetN,
   input  logic        wbValid,
   input  logic [4:0]  wbAddr,
   input  logic [31:0] wbData,
   input  logic        luValid,
   input  logic [4:0]  luAddr,
   input  logic [31:0] luData,
   output logic        luReady,
   input  logic        reserveValid,
   input  logic [4:0]  reserveAddr,
   input  logic [4:0]  readAddr1,
   input  logic [4:0]  readAddr2,
   input  logic        decodeWriteValid,
   input  logic [4:0]  decodeWriteAddr,
   output logic        hazardStall,
   output logic        starveStall,
   output logic        writeEnable,
   output logic [4:0]  writeAddr,
   output logic [31:0] writeData
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [31:0] busy_q, busy_d;
   logic [3:0]  starve_cnt_q, starve_cnt_d;
   logic        lu_accept;
   logic        reserve_ok;
   logic        we_d;
   logic [4:0]  waddr_d;
   logic [31:0] wdata_d;

   // Arbitration: writeback always wins.
   assign luReady   = luValid & ~wbValid;
   assign lu_accept = luValid & luReady;

   assign hazardStall = busy_q[readAddr1] | busy_q[readAddr2] |
                        (decodeWriteValid & busy_q[decodeWriteAddr]);

   assign reserve_ok = reserveValid & ~hazardStall;

   // Write-port capture; register 0 is captured but never strobed.
   always_comb begin
      we_d    = 1'b0;
      waddr_d = writeAddr;
      wdata_d = writeData;
      if (wbValid) begin
         we_d    = (wbAddr != '0);
         waddr_d = wbAddr;
         wdata_d = wbData;
      end else if (lu_accept) begin
         we_d    = (luAddr != '0);
         waddr_d = luAddr;
         wdata_d = luData;
      end
   end

   // Scoreboard update: clear first, then set, so a same-cycle set wins.
   always_comb begin
      busy_d = busy_q;
      if (lu_accept)
         busy_d[luAddr] = 1'b0;
      if (reserve_ok)
         busy_d[reserveAddr] = 1'b1;
      busy_d[0] = 1'b0;
   end

   // Starvation counter: counts lost arbitrations, saturates at LIMIT,
   // clears on acceptance or when the offer is withdrawn.
   always_comb begin
      starve_cnt_d = starve_cnt_q;
      if (!luValid || luReady)
         starve_cnt_d = '0;
      else if (starve_cnt_q != LIMIT)
         starve_cnt_d = starve_cnt_q + 4'd1;
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         writeEnable  <= 1'b0;
         writeAddr    <= '0;
         writeData    <= '0;
         busy_q       <= '0;
         starve_cnt_q <= '0;
         starveStall  <= 1'b0;
      end else begin
         writeEnable  <= we_d;
         writeAddr    <= waddr_d;
         writeData    <= wdata_d;
         busy_q       <= busy_d;
         starve_cnt_q <= starve_cnt_d;
         // Registered from the next count so the stall appears in the same
         // cycle the counter holds LIMIT and drops the cycle after acceptance.
         starveStall  <= (starve_cnt_d == LIMIT);
      end
   end

endmodule

// File: tb/tb_mips_control_register_write_scheduler.sv
module tb_mips_control_register_write_scheduler;

   logic        clock = 1'b0;
   logic        resetN;
   logic        wbValid;
   logic [4:0]  wbAddr;
   logic [31:0] wbData;
   logic        luValid;
   logic [4:0]  luAddr;
   logic [31:0] luData;
   logic        luReady;
   logic        reserveValid;
   logic [4:0]  reserveAddr;
   logic [4:0]  readAddr1;
   logic [4:0]  readAddr2;
   logic        decodeWriteValid;
   logic [4:0]  decodeWriteAddr;
   logic        hazardStall;
   logic        starveStall;
   logic        writeEnable;
   logic [4:0]  writeAddr;
   logic [31:0] writeData;

   int errors = 0;
   int checks = 0;

   logic [36:0] exp_q[$];

   mips_control_register_write_scheduler #(.STARVE_LIMIT(4)) dut (
      .clock(clock), .resetN(resetN),
      .wbValid(wbValid), .wbAddr(wbAddr), .wbData(wbData),
      .luValid(luValid), .luAddr(luAddr), .luData(luData), .luReady(luReady),
      .reserveValid(reserveValid), .reserveAddr(reserveAddr),
      .readAddr1(readAddr1), .readAddr2(readAddr2),
      .decodeWriteValid(decodeWriteValid), .decodeWriteAddr(decodeWriteAddr),
      .hazardStall(hazardStall), .starveStall(starveStall),
      .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every register-file write must match the oldest expectation.
   always @(negedge clock) begin
      if (resetN === 1'b1 && writeEnable === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {27'd0, writeAddr, writeData}, 64'h0);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            check("write_port", {27'd0, writeAddr, writeData}, {27'd0, e});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      wbValid = 0; wbAddr = 0; wbData = 0;
      luValid = 0; luAddr = 0; luData = 0;
      reserveValid = 0; reserveAddr = 0;
      readAddr1 = 0; readAddr2 = 0;
      decodeWriteValid = 0; decodeWriteAddr = 0;
   endtask

   initial begin
      resetN = 0;
      idle_inputs();
      repeat (2) @(negedge clock);
      check("rst_we", writeEnable, 0);
      check("rst_waddr", writeAddr, 0);
      check("rst_wdata", writeData, 0);
      check("rst_starve", starveStall, 0);
      check("rst_hazard", hazardStall, 0);
      next_cycle();
      resetN = 1;

      // Arbitration: writeback wins, long-latency unit follows.
      next_cycle();
      wbValid = 1; wbAddr = 3; wbData = 32'hAAAA0000;
      luValid = 1; luAddr = 7; luData = 32'h1234;
      exp_q.push_back({5'd3, 32'hAAAA0000});
      @(negedge clock);
      check("arb_luready_lost", luReady, 0);
      next_cycle();
      wbValid = 0;
      exp_q.push_back({5'd7, 32'h1234});
      @(negedge clock);
      check("arb_luready_won", luReady, 1);
      next_cycle();
      idle_inputs();
      @(negedge clock);
      check("arb_luready_idle", luReady, 0);

      // Scoreboard: reserve 9, stall on RAW/WAW until the result is accepted.
      next_cycle();
      reserveValid = 1; reserveAddr = 9; readAddr2 = 9;
      @(negedge clock);
      check("sb_hazard_before_set", hazardStall, 0);
      next_cycle();
      reserveValid = 0;
      @(negedge clock);
      check("sb_raw_stall", hazardStall, 1);
      next_cycle();
      readAddr2 = 0; decodeWriteValid = 1; decodeWriteAddr = 9;
      @(negedge clock);
      check("sb_waw_stall", hazardStall, 1);
      next_cycle();
      decodeWriteValid = 0;
      @(negedge clock);
      check("sb_waw_not_writing", hazardStall, 0);
      next_cycle();
      readAddr2 = 9; luValid = 1; luAddr = 9; luData = 32'h99;
      exp_q.push_back({5'd9, 32'h99});
      @(negedge clock);
      check("sb_stall_accept_cycle", hazardStall, 1);
      check("sb_luready", luReady, 1);
      next_cycle();
      luValid = 0;
      @(negedge clock);
      check("sb_unstall", hazardStall, 0);

      // Register 0: never written, never reserved.
      next_cycle();
      idle_inputs();
      wbValid = 1; wbAddr = 0; wbData = 32'hDEAD;
      reserveValid = 1; reserveAddr = 0;
      next_cycle();
      idle_inputs();
      @(negedge clock);
      check("r0_no_write", writeEnable, 0);
      check("r0_no_stall", hazardStall, 0);

      // Simultaneous set and clear of register 12: set wins.
      next_cycle();
      reserveValid = 1; reserveAddr = 12;
      next_cycle();
      luValid = 1; luAddr = 12; luData = 32'hC;
      exp_q.push_back({5'd12, 32'hC});
      @(negedge clock);
      check("sim_luready", luReady, 1);
      next_cycle();
      idle_inputs();
      readAddr1 = 12;
      @(negedge clock);
      check("sim_busy_kept", hazardStall, 1);
      next_cycle();
      luValid = 1; luAddr = 12; luData = 32'hC2;
      exp_q.push_back({5'd12, 32'hC2});
      next_cycle();
      luValid = 0;
      @(negedge clock);
      check("sim_cleared", hazardStall, 0);

      // Starvation: both valid for 6 cycles, stall from the 5th.
      next_cycle();
      idle_inputs();
      for (int i = 1; i <= 6; i++) begin
         wbValid = 1; wbAddr = 5'(16 + i); wbData = 32'h100 + 32'(i);
         luValid = 1; luAddr = 25; luData = 32'h2525;
         exp_q.push_back({5'(16 + i), 32'h100 + 32'(i)});
         @(negedge clock);
         check("starve_luready", luReady, 0);
         check($sformatf("starve_cycle%0d", i), starveStall, (i >= 5) ? 1 : 0);
         next_cycle();
      end
      wbValid = 0;
      exp_q.push_back({5'd25, 32'h2525});
      @(negedge clock);
      check("starve_accept_luready", luReady, 1);
      check("starve_still_high", starveStall, 1);
      next_cycle();
      idle_inputs();
      @(negedge clock);
      check("starve_released", starveStall, 0);

      // Reset mid-operation discards captured write and reservations.
      next_cycle();
      wbValid = 1; wbAddr = 4; wbData = 32'h44;
      reserveValid = 1; reserveAddr = 20;
      next_cycle();
      idle_inputs();
      check("pre_rst_write_present", writeEnable, 1);
      #1 resetN = 0;
      #1;
      check("mid_rst_we", writeEnable, 0);
      check("mid_rst_waddr", writeAddr, 0);
      check("mid_rst_wdata", writeData, 0);
      check("mid_rst_starve", starveStall, 0);
      next_cycle();
      resetN = 1;
      readAddr1 = 5;
      @(negedge clock);
      check("post_rst_hazard5", hazardStall, 0);
      next_cycle();
      readAddr1 = 20;
      @(negedge clock);
      check("post_rst_reservation_gone", hazardStall, 0);

      repeat (2) next_cycle();
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_control_register_write_scheduler.md
# mips_control_register_write_scheduler

Shares the single register-file write port between the in-order pipeline writeback stage and one long-latency unit (multiply/divide or cache-refill load), and keeps a 32-entry pending-write scoreboard so decode stalls on hazards against long-latency destinations. It sits beside the register control signal generator. Its registered write port drives the register file directly, replacing the writeback stage's direct connection.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive cycles a long-latency request may lose arbitration before `starveStall` asserts; legal range 1..15.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- resetN  input  1  asynchronous, active-low reset.
- wbValid  input  1  pipeline writeback has a result this cycle; never back-pressured.
- wbAddr  input  5  writeback destination register.
- wbData  input  32  writeback data.
- luValid  input  1  long-latency unit offers a result.
- luAddr  input  5  long-latency destination register.
- luData  input  32  long-latency data.
- luReady  output  1  long-latency result accepted this cycle (valid/ready handshake).
- reserveValid  input  1  decode issues a long-latency op this cycle.
- reserveAddr  input  5  destination reserved by that op.
- readAddr1  input  5  decode rs.
- readAddr2  input  5  decode rt.
- decodeWriteValid  input  1  decode instruction writes a register (from writeEnable control).
- decodeWriteAddr  input  5  its destination.
- hazardStall  output  1  hold decode this cycle.
- starveStall  output  1  hold fetch/decode so the pipeline drains a writeback bubble.
- writeEnable  output  1  register file write strobe.
- writeAddr  output  5  register file write address.
- writeData  output  32  register file write data.

## Operation
- Arbitration: wbValid has absolute priority. luReady = luValid & ~wbValid (combinational).
- Winner is captured into the write-port register. Register-0 writes are captured with writeEnable forced 0.
- Scoreboard busy[31:1]; busy[0] is constant 0.
  - Set by reserveValid & ~hazardStall, at reserveAddr (nonzero addresses only).
  - Cleared by luValid & luReady, at luAddr.
- Same-cycle set and clear of one address: set wins.
- Reserving an already-busy address is prevented by the stall. If it occurs anyway, the bit stays set.
- hazardStall = busy[readAddr1] | busy[readAddr2] | (decodeWriteValid & busy[decodeWriteAddr]). This covers RAW and WAW.
- Registers at address 0 never stall.
- Starvation counter (4 bits):
  - Increments each cycle luValid & wbValid.
  - Resets to 0 when luValid is low or luReady is high.
  - Saturates at STARVE_LIMIT.
- starveStall = (counter == STARVE_LIMIT), registered. It stays high until the long-latency result is accepted.
- luValid deasserted without acceptance is a protocol violation. The counter clears.

## Timing
- Reset (resetN low, asynchronous):
  - writeEnable=0, writeAddr=0, writeData=0.
  - busy all 0, counter 0, starveStall=0.
  - hazardStall=0 whenever busy is clear.
  - luReady follows inputs.
- Write latency: accepted result appears on writeEnable/writeAddr/writeData one cycle after acceptance. The register file writes at the following edge.
- Busy bit clears at the same edge that loads the write-port register. The dependent instruction unstalls the cycle the write-port register holds the result, and the register file commits it at the end of that cycle.
  - The register file must forward its write port to reads in the same cycle.
- Busy bit set at the edge after reserveValid; hazardStall reflects it from the next cycle.
- starveStall rises one cycle after the counter reaches STARVE_LIMIT. It falls one cycle after luReady.
- Reset mid-operation discards any captured write (writeEnable drops immediately) and all reservations.

## Test plan
- Reset: hold resetN low mid-traffic -> all outputs 0 asynchronously; after release, readAddr1=5 with no reservations gives hazardStall=0.
- Arbitration: wbValid=1 (addr 3, 0xAAAA0000) and luValid=1 (addr 7, 0x1234) in the same cycle.
  - Next cycle: write 3/0xAAAA0000, luReady=0.
  - Then wbValid=0: luReady=1, and the following cycle writes 7/0x1234.
- Scoreboard: reserve addr 9.
  - Next cycle readAddr2=9 -> hazardStall=1 until the addr-9 lu result is accepted.
  - hazardStall=0 in the cycle after acceptance.
  - decodeWriteAddr=9 also stalls while busy.
- Starvation: STARVE_LIMIT=4, wbValid and luValid held high -> starveStall=1 on the 5th cycle; drop wbValid -> luReady=1, starveStall=0 the next cycle.
- Register 0: wbAddr=0 -> writeEnable=0; reserveAddr=0 -> no stall on readAddr1=0.
- Simultaneous set/clear: lu result for addr 12 accepted in the same cycle as reserveValid for addr 12 -> busy[12] remains 1.
